noc_flit_depacketizer: RTL

- Ejection-side network interface: consumes the flit stream leaving a router's LOCAL port and reassembles it into one packet message for the attached core.
- Decodes the noc_params flit_t format: HEAD carries x_dest, y_dest and a 58-bit head payload; BODY and TAIL each carry a 62-bit payload.
- Counterpart of the injection packetizer.
- Checks flit-sequence legality, checks destination against the local tile coordinates, and reports truncation and drops.

---
 rtl/noc_flit_depacketizer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/noc_flit_depacketizer.sv
// noc_flit_depacketizer: ejection-side network interface.
// Reassembles LOCAL-port flits into one message for the core.
module noc_flit_depacketizer #(
  parameter logic [1:0]  LOCAL_X      = 2'd0,
  parameter logic [1:0]  LOCAL_Y      = 2'd0,
  parameter int unsigned MAX_PL_FLITS = 4,
  localparam int unsigned FLIT_WIDTH        = 64,
  localparam int unsigned DEST_ADDR_SIZE_X  = 2,
  localparam int unsigned DEST_ADDR_SIZE_Y  = 2,
  localparam int unsigned HEAD_PAYLOAD_SIZE = 58,
  localparam int unsigned BODY_PAYLOAD_SIZE = 62,
  localparam int unsigned PL_W = MAX_PL_FLITS * BODY_PAYLOAD_SIZE,
  localparam int unsigned CW   = $clog2(MAX_PL_FLITS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flit_valid_i,
  output logic                         flit_ready_o,
  input  logic [FLIT_WIDTH-1:0]        flit_i,
  output logic                         msg_valid_o,
  input  logic                         msg_ready_i,
  output logic [DEST_ADDR_SIZE_X-1:0]  msg_x_dest_o,
  output logic [DEST_ADDR_SIZE_Y-1:0]  msg_y_dest_o,
  output logic [HEAD_PAYLOAD_SIZE-1:0] msg_head_pl_o,
  output logic [PL_W-1:0]              msg_pl_o,
  output logic [CW-1:0]                msg_pl_cnt_o,
  output logic                         msg_trunc_o,
  output logic                         msg_misroute_o,
  output logic [7:0]                   drop_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  localparam logic [1:0] LBL_HEAD = 2'b00;
  localparam logic [1:0] LBL_BODY = 2'b01;
  localparam logic [1:0] LBL_TAIL = 2'b10;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PL_FLITS);

  state_t state_q, state_d;

  logic [DEST_ADDR_SIZE_X-1:0]  x_q;
  logic [DEST_ADDR_SIZE_Y-1:0]  y_q;
  logic [HEAD_PAYLOAD_SIZE-1:0] hpl_q;
  logic [PL_W-1:0]              pl_q;
  logic [CW-1:0]                cnt_q;
  logic                         trunc_q;
  logic                         misroute_q;
  logic [7:0]                   drop_q;

  logic [1:0] label;
  logic       is_head, is_body, is_tail, is_bad;
  logic       take;
  logic       latch_head, store_pl, drop;
  logic [DEST_ADDR_SIZE_X-1:0]  f_x;
  logic [DEST_ADDR_SIZE_Y-1:0]  f_y;
  logic [HEAD_PAYLOAD_SIZE-1:0] f_hpl;
  logic [BODY_PAYLOAD_SIZE-1:0] f_bpl;

  assign label   = flit_i[63:62];
  assign f_x     = flit_i[61:60];
  assign f_y     = flit_i[59:58];
  assign f_hpl   = flit_i[57:0];
  assign f_bpl   = flit_i[61:0];
  assign is_head = (label == LBL_HEAD);
  assign is_body = (label == LBL_BODY);
  assign is_tail = (label == LBL_TAIL);
  assign is_bad  = (label == 2'b11);

  // Ready depends on registered state only, never on msg_ready_i.
  assign flit_ready_o = (state_q != HOLD);
  assign msg_valid_o  = (state_q == HOLD);
  assign take         = flit_valid_i && flit_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    latch_head = 1'b0;
    store_pl   = 1'b0;
    drop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          if (is_head) begin
            latch_head = 1'b1;
            state_d    = COLLECT;
          end else begin
            drop = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (take) begin
          unique case (1'b1)
            is_head: begin
              latch_head = 1'b1;
              drop       = 1'b1;
            end
            is_body: store_pl = 1'b1;
            is_tail: begin
              store_pl = 1'b1;
              state_d  = HOLD;
            end
            is_bad:  drop = 1'b1;
            default: drop = 1'b1;
          endcase
        end
      end
      HOLD: begin
        if (msg_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      hpl_q      <= '0;
      pl_q       <= '0;
      cnt_q      <= '0;
      trunc_q    <= 1'b0;
      misroute_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (latch_head) begin
        x_q        <= f_x;
        y_q        <= f_y;
        hpl_q      <= f_hpl;
        misroute_q <= (f_x != LOCAL_X) || (f_y != LOCAL_Y);
        cnt_q      <= '0;
        trunc_q    <= 1'b0;
      end
      if (store_pl) begin
        if (cnt_q < MAX_CNT) begin
          for (int k = 0; k < int'(MAX_PL_FLITS); k++) begin
            if (cnt_q == CW'(k))
              pl_q[k*BODY_PAYLOAD_SIZE +: BODY_PAYLOAD_SIZE] <= f_bpl;
          end
          cnt_q <= cnt_q + 1'b1;
        end else begin
          trunc_q <= 1'b1;
        end
      end
      if (drop && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
    end
  end

  assign msg_x_dest_o   = x_q;
  assign msg_y_dest_o   = y_q;
  assign msg_head_pl_o  = hpl_q;
  assign msg_pl_o       = pl_q;
  assign msg_pl_cnt_o   = cnt_q;
  assign msg_trunc_o    = trunc_q;
  assign msg_misroute_o = misroute_q;
  assign drop_cnt_o     = drop_q;

endmodule
